// File: rtl/sram_pkg.sv
// Shared types and defaults for the memory-stage SRAM controller.
package sram_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int unsigned DATA_BASE_DEFAULT     = 1024;
  localparam int unsigned ACCESS_CYCLES_DEFAULT = 2;
  localparam int unsigned CNT_W                 = 4;

  // Half-word select appended as the SRAM address LSB
  localparam logic LO = 1'b0;
  localparam logic HI = 1'b1;

endpackage

// File: rtl/sram_controller.sv
// 32-bit LDR/STR over a 16-bit async SRAM, two half-word accesses per word.
// Optional SRAM_READ_REUSE_EN: repeat reads of the last word skip the SRAM.
module sram_controller
  import sram_pkg::*;
#(
  parameter int unsigned SRAM_ADDR_W   = 18,
  parameter int unsigned DATA_BASE     = DATA_BASE_DEFAULT,
  parameter int unsigned ACCESS_CYCLES = ACCESS_CYCLES_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  inout  wire  [15:0]            SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ACCESS_CYCLES - 1);

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [29:0]              word_q, word_d, cur_word;
  logic [31:0]              wdata_q, wdata_d, rdata_d;
  logic                     phase_end;
  logic                     in_phase, in_rd, in_wr, half_d;
  logic [SRAM_ADDR_W-1:0]   addr_d;
  logic                     we_n_d;
  logic                     dq_oe, dq_oe_d;
  logic [15:0]              dq_out, dq_out_d;
`ifdef SRAM_READ_REUSE_EN
  logic [29:0]              tag_q, tag_d;
  logic                     tag_valid_q, tag_valid_d;
`endif

  // Word index relative to the data base; wraps modulo 2^32 below the base
  assign cur_word  = 30'((address - 32'(DATA_BASE)) >> 2);
  assign phase_end = (cnt_q == LAST);
  assign ready     = ~(rd_en | wr_en) | (state_q == DONE);
  assign SRAM_DQ   = dq_oe ? dq_out : {16{1'bz}};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    word_d  = word_q;
    wdata_d = wdata_q;
    rdata_d = read_data;
`ifdef SRAM_READ_REUSE_EN
    tag_d       = tag_q;
    tag_valid_d = tag_valid_q;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (wr_en) begin
          state_d = WR_LO;
          word_d  = cur_word;
          wdata_d = write_data;
`ifdef SRAM_READ_REUSE_EN
          tag_valid_d = 1'b0;
`endif
        end else if (rd_en) begin
`ifdef SRAM_READ_REUSE_EN
          if (tag_valid_q && (tag_q == cur_word)) begin
            state_d = DONE;
          end else begin
            state_d = RD_LO;
            word_d  = cur_word;
          end
`else
          state_d = RD_LO;
          word_d  = cur_word;
`endif
        end
      end
      RD_LO: if (phase_end) begin
        state_d        = RD_HI;
        cnt_d          = '0;
        rdata_d[15:0]  = SRAM_DQ;
      end
      RD_HI: if (phase_end) begin
        state_d        = DONE;
        cnt_d          = '0;
        rdata_d[31:16] = SRAM_DQ;
`ifdef SRAM_READ_REUSE_EN
        tag_d       = word_q;
        tag_valid_d = 1'b1;
`endif
      end
      WR_LO: if (phase_end) begin
        state_d = WR_HI;
        cnt_d   = '0;
      end
      WR_HI: if (phase_end) begin
        state_d = DONE;
        cnt_d   = '0;
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Bus controls are decoded from the next state so they register in step with it
    in_rd    = (state_d == RD_LO) || (state_d == RD_HI);
    in_wr    = (state_d == WR_LO) || (state_d == WR_HI);
    in_phase = in_rd || in_wr;
    half_d   = ((state_d == RD_HI) || (state_d == WR_HI)) ? HI : LO;
    addr_d   = in_phase ? SRAM_ADDR_W'({word_d, half_d}) : SRAM_ADDR;
    // Last write cycle keeps WE_N high for address/data hold
    we_n_d   = ~(in_wr && (cnt_d != LAST));
    dq_oe_d  = in_wr;
    dq_out_d = (half_d == HI) ? wdata_d[31:16] : wdata_d[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      word_q    <= '0;
      wdata_q   <= '0;
      read_data <= '0;
      SRAM_ADDR <= '0;
      SRAM_CE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      SRAM_WE_N <= 1'b1;
      SRAM_UB_N <= 1'b1;
      SRAM_LB_N <= 1'b1;
      dq_oe     <= 1'b0;
      dq_out    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      wdata_q   <= wdata_d;
      read_data <= rdata_d;
      SRAM_ADDR <= addr_d;
      SRAM_CE_N <= ~in_phase;
      SRAM_OE_N <= ~in_rd;
      SRAM_WE_N <= we_n_d;
      SRAM_UB_N <= ~in_phase;
      SRAM_LB_N <= ~in_phase;
      dq_oe     <= dq_oe_d;
      dq_out    <= dq_out_d;
    end
  end

`ifdef SRAM_READ_REUSE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q       <= '0;
      tag_valid_q <= 1'b0;
    end else begin
      tag_q       <= tag_d;
      tag_valid_q <= tag_valid_d;
    end
  end
`endif

endmodule

// File: tb/tb_sram_controller.sv
// Randomized bench for sram_controller: async SRAM model plus a word-level
// reference memory, latency model and optional read-reuse tag model.
module tb_sram_controller;

  localparam int AC = 2;
  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          rst, rd_en, wr_en;
  logic [31:0]   address, write_data;
  logic [31:0]   read_data;
  logic          ready;
  wire  [15:0]   SRAM_DQ;
  logic [AW-1:0] SRAM_ADDR;
  logic          SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;

  sram_controller #(.SRAM_ADDR_W(AW), .DATA_BASE(1024), .ACCESS_CYCLES(AC)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR), .SRAM_CE_N(SRAM_CE_N),
    .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N), .SRAM_UB_N(SRAM_UB_N),
    .SRAM_LB_N(SRAM_LB_N)
  );

  always #5 clk = ~clk;

  // Async SRAM model; park_en drives a known pattern to expose a stray DUT driver
  logic [15:0] mem [0:(1<<AW)-1];
  logic [15:0] sram_val;
  logic        sram_drive;
  logic        park_en = 1'b0;
  assign sram_val   = mem[SRAM_ADDR];
  assign sram_drive = !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;
  assign SRAM_DQ    = sram_drive ? sram_val : (park_en ? 16'h5A5A : 16'hzzzz);

  int ce_cnt, oe_cnt, we_cnt, be_bad;
  logic [31:0] log_a[$];
  logic [31:0] log_d[$];

  always @(negedge clk) begin
    if (!SRAM_CE_N) begin
      ce_cnt++;
      if (SRAM_UB_N || SRAM_LB_N) be_bad++;
    end
    if (!SRAM_OE_N) oe_cnt++;
    if (!SRAM_CE_N && !SRAM_WE_N) begin
      we_cnt++;
      mem[SRAM_ADDR] = SRAM_DQ;
      log_a.push_back(32'(SRAM_ADDR));
      log_d.push_back(32'(SRAM_DQ));
    end
  end

  // Reference state
  logic [31:0] ref_mem [int];
  logic [31:0] ref_rdata;
  bit          tag_v;
  logic [31:0] tag_w;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ctrl_bits();
    return 32'({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N});
  endfunction

  // One transfer starting in an IDLE cycle (called right after a negedge)
  task automatic xfer(input bit rd, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wd, input int drop_at);
    logic [31:0] w, lo_a, key, exp_rd, ea, ed;
    bit hit, done;
    int lat, exp_lat, per_phase;
    w         = (addr - 32'd1024) >> 2;
    lo_a      = (w << 1) & ((32'd1 << AW) - 32'd1);
    key       = lo_a >> 1;
    hit       = 1'b0;
`ifdef SRAM_READ_REUSE_EN
    hit = rd && !wr && tag_v && (tag_w == w);
`endif
    exp_lat   = hit ? 1 : 1 + 2 * AC;
    per_phase = AC - 1;
    log_a.delete(); log_d.delete();
    ce_cnt = 0; oe_cnt = 0; we_cnt = 0;
    rd_en = rd; wr_en = wr; address = addr; write_data = wd;
    lat = 0; done = 1'b0;
    while (!done && lat < 64) begin
      @(negedge clk);
      lat++;
      if (drop_at > 0) begin
        if (lat == drop_at) begin rd_en = 1'b0; wr_en = 1'b0; end
        if (lat == exp_lat + 1) done = 1'b1;
      end else if (ready) begin
        done = 1'b1;
      end else begin
        address = $urandom; write_data = $urandom;
      end
    end
    if (drop_at == 0) check("latency", 32'(lat), 32'(exp_lat));
    check("ce_cycles", 32'(ce_cnt), 32'(hit ? 0 : 2 * AC));
    if (wr) begin
      check("we_cycles", 32'(we_cnt), 32'(2 * per_phase));
      check("oe_cycles", 32'(oe_cnt), 32'd0);
      for (int i = 0; i < log_a.size(); i++) begin
        ea = (i >= per_phase) ? lo_a + 32'd1 : lo_a;
        ed = (i >= per_phase) ? {16'd0, wd[31:16]} : {16'd0, wd[15:0]};
        check("wr_addr", log_a[i], ea);
        check("wr_data", log_d[i], ed);
      end
      check("rd_hold", read_data, ref_rdata);
      ref_mem[int'(key)] = wd;
      tag_v = 1'b0;
    end else begin
      exp_rd = ref_mem.exists(int'(key)) ? ref_mem[int'(key)] : 32'd0;
      check("rd_data", read_data, exp_rd);
      check("we_cycles", 32'(we_cnt), 32'd0);
      ref_rdata = exp_rd;
      if (!hit) begin tag_v = 1'b1; tag_w = w; end
    end
    rd_en = 1'b0; wr_en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] wd;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'd0;
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
    ref_rdata = '0; tag_v = 1'b0; tag_w = '0;
    ce_cnt = 0; oe_cnt = 0; we_cnt = 0; be_bad = 0;
    repeat (2) @(negedge clk);
    check("rst_rdata", read_data, 32'd0);
    check("rst_ctrl", ctrl_bits(), 32'h1f);
    check("rst_addr", 32'(SRAM_ADDR), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(ready), 32'd1);

    // Directed: write/readback, reuse, priority, freeze, wrap
    xfer(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 0);
    check("w1032_lo_addr", log_a[0], 32'd4);
    check("w1032_lo_data", log_d[0], 32'h0000BEEF);
    check("w1032_hi_addr", log_a[log_a.size()-1], 32'd5);
    check("w1032_hi_data", log_d[log_d.size()-1], 32'h0000DEAD);
    xfer(1'b1, 1'b0, 32'd1032, 32'h0, 0);
    check("r1032", read_data, 32'hDEADBEEF);
    xfer(1'b1, 1'b0, 32'd1035, 32'h0, 0);
    check("r1035", read_data, 32'hDEADBEEF);
    xfer(1'b0, 1'b1, 32'd1032, 32'h13572468, 0);
    xfer(1'b1, 1'b0, 32'd1032, 32'h0, 0);
    xfer(1'b1, 1'b1, 32'd1040, 32'hCAFEF00D, 0);
    xfer(1'b1, 1'b0, 32'd1040, 32'h0, 0);
    xfer(1'b0, 1'b1, 32'd1044, 32'h0BADC0DE, 2);
    xfer(1'b1, 1'b0, 32'd1044, 32'h0, 0);
    xfer(1'b0, 1'b1, 32'd1020, 32'h89ABCDEF, 0);
    check("wrap_lo_addr", log_a[0], 32'h3FFFE);
    check("wrap_hi_addr", log_a[log_a.size()-1], 32'h3FFFF);
    xfer(1'b1, 1'b0, 32'd1020, 32'h0, 0);

    // Reset in the last cycle of WR_HI (both write strobes already issued)
    wd = 32'hA5A5C3C3;
    rd_en = 1'b0; wr_en = 1'b1; address = 32'd1100; write_data = wd;
    repeat (2 * AC) @(negedge clk);
    rst = 1'b1; park_en = 1'b1;
    #1;
    check("abort_ctrl", ctrl_bits(), 32'h1f);
    check("abort_dq", 32'(SRAM_DQ), 32'h5A5A);
    check("abort_rdata", read_data, 32'd0);
    @(negedge clk);
    rst = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    park_en = 1'b0;
    check("post_rst_ready", 32'(ready), 32'd1);
    check("post_rst_ctrl", ctrl_bits(), 32'h1f);
    ref_mem[int'(((32'd1100 - 32'd1024) >> 2) & 32'h1FFFF)] = wd;
    ref_rdata = 32'd0;
    tag_v = 1'b0;
    xfer(1'b1, 1'b0, 32'd1100, 32'h0, 0);

    // Randomized mix over a small address pool plus occasional far addresses
    for (int t = 0; t < 80; t++) begin
      int op;
      logic [31:0] a;
      op = int'($urandom_range(0, 9));
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = 32'd1020 + 32'd4 * $urandom_range(0, 15) + $urandom_range(0, 3);
      if (op < 4)      xfer(1'b0, 1'b1, a, $urandom, 0);
      else if (op < 9) xfer(1'b1, 1'b0, a, $urandom, 0);
      else             xfer(1'b1, 1'b1, a, $urandom, 0);
    end

    check("byte_enables", 32'(be_bad), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
